// File: rtl/frog_input_ctrl_if.sv
// Keycode/control inputs and move/select outputs shared between frog_input_ctrl and its driver.
interface frog_input_ctrl_if;
  logic [7:0] keycode;
  logic       game_active;
  logic       dead_frog;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       frog_1_key;
  logic       frog_2_key;
  logic       frog_3_key;

  modport master (
    output keycode, game_active, dead_frog,
    input  up, down, left, right, frog_1_key, frog_2_key, frog_3_key
  );

  modport slave (
    input  keycode, game_active, dead_frog,
    output up, down, left, right, frog_1_key, frog_2_key, frog_3_key
  );
endinterface

// File: rtl/frog_input_ctrl.sv
// Turns the held keycode into single-frame move strobes with hold-to-repeat,
// and latches the frog selection from the number keys.
module frog_input_ctrl #(
  parameter int unsigned HOLD_DELAY    = 12,
  parameter int unsigned REPEAT_PERIOD = 6,
  parameter int unsigned CNT_W         = 6
) (
  input  logic              frame_clk,
  input  logic              Reset,
  frog_input_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       strobe_q, strobe_d;  // {up, down, left, right}
  logic [2:0]       sel_q, sel_d;        // {frog_1, frog_2, frog_3}

  logic             dir_vld;
  dir_t             dir_new;
  logic             sel_vld;
  logic [2:0]       sel_new;
  logic             fire;
  dir_t             fire_dir;
  logic [CNT_W-1:0] cnt_last;

  always_comb begin
    dir_vld = 1'b0;
    dir_new = DIR_UP;
    sel_vld = 1'b0;
    sel_new = '0;
    unique case (bus.keycode)
      8'h1A, 8'h52: begin dir_vld = 1'b1; dir_new = DIR_UP;    end
      8'h16, 8'h51: begin dir_vld = 1'b1; dir_new = DIR_DOWN;  end
      8'h04, 8'h50: begin dir_vld = 1'b1; dir_new = DIR_LEFT;  end
      8'h07, 8'h4F: begin dir_vld = 1'b1; dir_new = DIR_RIGHT; end
      8'h1E:        begin sel_vld = 1'b1; sel_new = 3'b100;    end
      8'h1F:        begin sel_vld = 1'b1; sel_new = 3'b010;    end
      8'h20:        begin sel_vld = 1'b1; sel_new = 3'b001;    end
      default:      ;
    endcase
  end

  assign cnt_last = (state_q == HOLD) ? HOLD_LAST : REP_LAST;

  // Death outranks the game gate, which outranks normal key handling.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    fire     = 1'b0;
    fire_dir = dir_q;
    if (bus.dead_frog) begin
      sel_d   = '0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!bus.game_active) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (sel_vld) sel_d = sel_new;
      unique case (state_q)
        IDLE: begin
          if (dir_vld) begin
            fire     = 1'b1;
            fire_dir = dir_new;
            dir_d    = dir_new;
            cnt_d    = '0;
            state_d  = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!dir_vld) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (dir_new != dir_q) begin
            fire     = 1'b1;
            fire_dir = dir_new;
            dir_d    = dir_new;
            cnt_d    = '0;
            state_d  = HOLD;
          end else if (cnt_q == cnt_last) begin
            fire    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    strobe_d = '0;
    if (fire) begin
      unique case (fire_dir)
        DIR_UP:    strobe_d = 4'b1000;
        DIR_DOWN:  strobe_d = 4'b0100;
        DIR_LEFT:  strobe_d = 4'b0010;
        DIR_RIGHT: strobe_d = 4'b0001;
        default:   strobe_d = '0;
      endcase
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      cnt_q    <= '0;
      strobe_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      sel_q    <= sel_d;
    end
  end

  assign bus.up         = strobe_q[3];
  assign bus.down       = strobe_q[2];
  assign bus.left       = strobe_q[1];
  assign bus.right      = strobe_q[0];
  assign bus.frog_1_key = sel_q[2];
  assign bus.frog_2_key = sel_q[1];
  assign bus.frog_3_key = sel_q[0];

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Bench for frog_input_ctrl: directed scenarios plus random key streams checked
// against an elapsed-frames model of press, hold and repeat.
module tb_frog_input_ctrl;
  localparam int HD = 12;
  localparam int RP = 6;

  logic frame_clk = 1'b0;
  logic Reset;

  frog_input_ctrl_if bus ();

  frog_input_ctrl #(.HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .CNT_W(6)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: frames elapsed since the current direction started being held (-1 = none).
  int         m_run;
  int         m_dir;
  logic [2:0] m_sel;
  logic [3:0] m_strobe;

  function automatic int dec_dir(input logic [7:0] k);
    case (k)
      8'h1A, 8'h52: return 0;
      8'h16, 8'h51: return 1;
      8'h04, 8'h50: return 2;
      8'h07, 8'h4F: return 3;
      default:      return -1;
    endcase
  endfunction

  function automatic logic [2:0] dec_sel(input logic [7:0] k);
    case (k)
      8'h1E:   return 3'b100;
      8'h1F:   return 3'b010;
      8'h20:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [6:0] obs();
    return {bus.up, bus.down, bus.left, bus.right,
            bus.frog_1_key, bus.frog_2_key, bus.frog_3_key};
  endfunction

  function automatic logic [6:0] expv();
    return {m_strobe, m_sel};
  endfunction

  task automatic model_reset();
    m_run    = -1;
    m_dir    = 0;
    m_sel    = 3'b000;
    m_strobe = 4'b0000;
  endtask

  // Drive one frame of inputs, take the edge, advance the model, settle.
  task automatic step(input logic [7:0] k, input logic ga, input logic dead);
    int d;
    bus.keycode     = k;
    bus.game_active = ga;
    bus.dead_frog   = dead;
    @(posedge frame_clk);
    d        = dec_dir(k);
    m_strobe = 4'b0000;
    if (Reset === 1'b0) begin
      model_reset();
    end else if (dead) begin
      m_sel = 3'b000;
      m_run = -1;
    end else if (!ga) begin
      m_run = -1;
    end else begin
      if (dec_sel(k) != 3'b000) m_sel = dec_sel(k);
      if (d < 0) begin
        m_run = -1;
      end else if (m_run < 0 || d != m_dir) begin
        m_dir    = d;
        m_run    = 0;
        m_strobe = 4'b1000 >> d;
      end else begin
        m_run++;
        if (m_run >= HD && (m_run - HD) % RP == 0) m_strobe = 4'b1000 >> d;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    model_reset();
    bus.keycode = 8'h1A; bus.game_active = 1'b1; bus.dead_frog = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 7'b0) $display("FAIL reset_async got=%b want=%b", obs(), 7'b0);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(8'h1A, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== 7'b0) $display("FAIL reset_held[%0d] got=%b want=%b", i, obs(), 7'b0);
      else n_pass++;
    end
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(8'h00, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_release[%0d] got=%b want=%b", i, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_tap();
    int ups = 0;
    for (int i = 0; i < 6; i++) begin
      step(i < 3 ? 8'h1A : 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL tap[%0d] got=%b want=%b", i, obs(), expv());
      else n_pass++;
      if (bus.up) ups++;
      if (i == 0) begin
        n_checks++;
        if (bus.up !== 1'b1) $display("FAIL tap_first got=%b want=1", bus.up);
        else n_pass++;
      end
    end
    n_checks++;
    if (ups != 1) $display("FAIL tap_count got=%0d want=1", ups);
    else n_pass++;
  endtask

  task automatic test_hold_repeat();
    int pulses[$];
    int want[$] = '{0, 12, 18, 24, 30};
    for (int i = 0; i <= 30; i++) begin
      step(8'h4F, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL hold[%0d] got=%b want=%b", i, obs(), expv());
      else n_pass++;
      if (bus.right) pulses.push_back(i);
    end
    n_checks++;
    if (pulses != want) $display("FAIL hold_edges got=%p want=%p", pulses, want);
    else n_pass++;
    step(8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_dir_change();
    int lefts = 0;
    int downs[$];
    int want[$] = '{5, 17};
    for (int i = 0; i <= 20; i++) begin
      step(i < 5 ? 8'h04 : 8'h16, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL dirchg[%0d] got=%b want=%b", i, obs(), expv());
      else n_pass++;
      if (bus.left && i > 0) lefts++;
      if (bus.down) downs.push_back(i);
    end
    n_checks++;
    if (lefts != 0 || downs != want)
      $display("FAIL dirchg_edges got=left%0d,down%p want=left0,down%p", lefts, downs, want);
    else n_pass++;
    step(8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_select_death();
    logic [7:0] ks[8] = '{8'h1F, 8'h00, 8'h00, 8'h1A, 8'h1A, 8'h1A, 8'h1A, 8'h1E};
    logic       dd[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(ks[i], 1'b1, dd[i]);
      n_checks++;
      if (obs() !== expv()) $display("FAIL seldeath[%0d] got=%b want=%b", i, obs(), expv());
      else n_pass++;
      if (i == 2) begin
        n_checks++;
        if (bus.frog_2_key !== 1'b1) $display("FAIL sel_persist got=%b want=1", bus.frog_2_key);
        else n_pass++;
      end
      if (i == 5) begin
        n_checks++;
        if (obs() !== 7'b0) $display("FAIL death got=%b want=%b", obs(), 7'b0);
        else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (bus.up !== 1'b1) $display("FAIL after_death_up got=%b want=1", bus.up);
        else n_pass++;
      end
    end
    step(8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_game_over_reset();
    for (int i = 0; i < 4; i++) begin
      step(i == 0 ? 8'h52 : 8'h20, 1'b0, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL gameover[%0d] got=%b want=%b", i, obs(), expv());
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      step(8'h52, 1'b1, 1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL resume[%0d] got=%b want=%b", i, obs(), expv());
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (bus.up !== 1'b1) $display("FAIL resume_up got=%b want=1", bus.up);
        else n_pass++;
      end
    end
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== 7'b0) $display("FAIL midhold_reset got=%b want=%b", obs(), 7'b0);
    else n_pass++;
    step(8'h52, 1'b1, 1'b0);
    Reset = 1'b1;
    step(8'h52, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== expv() || bus.up !== 1'b1)
      $display("FAIL post_reset_up got=%b want=%b", obs(), expv());
    else n_pass++;
    step(8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] pool[13] = '{8'h00, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h04, 8'h50,
                             8'h07, 8'h4F, 8'h1E, 8'h1F, 8'h20, 8'h33};
    logic [7:0] k;
    int         left_frames = 0;
    logic [3:0] prev = 4'b0;
    logic [3:0] cur;
    for (int i = 0; i < 500; i++) begin
      if (left_frames == 0) begin
        k = pool[$urandom_range(12, 0)];
        left_frames = $urandom_range(25, 1);
      end
      left_frames--;
      step(k, ($urandom_range(15, 0) != 0), ($urandom_range(39, 0) == 0));
      cur = obs() >> 3;
      n_checks++;
      if (obs() !== expv()) $display("FAIL random[%0d] key=%h got=%b want=%b", i, k, obs(), expv());
      else n_pass++;
      n_checks++;
      if ($countones(cur) > 1 || (cur & prev) != 4'b0)
        $display("FAIL strobe_rules[%0d] got=%b prev=%b want=onehot_nonrepeat", i, cur, prev);
      else n_pass++;
      prev = cur;
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_repeat();
    test_dir_change();
    test_select_death();
    test_game_over_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
